// File: rtl/issue_wb_pkg.sv
// Shared types for the issue interlock and writeback scheduler.
// Register address width, result entry layout and arbiter side.
package issue_wb_pkg;

  localparam int REG_ADR_W = 3;
  localparam int NUM_REGS  = 8;
  localparam int WB_DATA_W = 16;

  typedef struct packed {
    logic [REG_ADR_W-1:0] adr;
    logic [WB_DATA_W-1:0] data;
  } wb_entry_t;

  typedef enum logic {
    RR_ALU = 1'b0,
    RR_MEM = 1'b1
  } rr_e;

endpackage

// File: rtl/issue_wb_ctrl_wb_fifo.sv
// Small synchronous FIFO holding ALU results awaiting the write port.
// Entries become visible to the reader one cycle after the push.
module wb_fifo
  import issue_wb_pkg::*;
#(
  parameter int  DEPTH = 2,
  parameter type T     = wb_entry_t,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push_i,
  input  T              wdata_i,
  input  logic          pop_i,
  output T              rdata_o,
  output logic [CW-1:0] count_o,
  output logic          empty_o,
  output logic          full_o
);

  T              mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok;
  logic          pop_ok;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign pop_ok  = pop_i & ~empty_o;
  assign push_ok = push_i & (~full_o | pop_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok)
      wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
    if (pop_ok)
      rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok)
      mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/issue_wb_ctrl.sv
// Issue interlock, ALU credit tracking and round-robin sharing of
// the single register-file write port between ALU and memory results.
module issue_wb_ctrl
  import issue_wb_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int ALU_BUF = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REGS-1:0]  register_invalid,
  input  logic                 id_valid,
  input  logic [REG_ADR_W-1:0] id_rs_adr,
  input  logic                 id_rs_use,
  input  logic [REG_ADR_W-1:0] id_rt_adr,
  input  logic                 id_rt_use,
  input  logic [REG_ADR_W-1:0] id_rd_adr,
  input  logic                 id_rd_write,
  input  logic                 id_is_load,
  output logic                 id_stall,
  output logic                 regwrite_cur,
  output logic [REG_ADR_W-1:0] regwrite_adr_id,
  input  logic                 alu_wb_valid,
  input  logic [REG_ADR_W-1:0] alu_wb_adr,
  input  logic [DATA_W-1:0]    alu_wb_data,
  input  logic                 mem_wb_valid,
  input  logic [REG_ADR_W-1:0] mem_wb_adr,
  input  logic [DATA_W-1:0]    mem_wb_data,
  output logic                 mem_wb_ready,
  output logic                 regwrite,
  output logic [REG_ADR_W-1:0] regwrite_adr,
  output logic [DATA_W-1:0]    regwrite_data
);

  localparam int CRW = $clog2(ALU_BUF + 1);
  localparam int FCW = $clog2(ALU_BUF + 1);

  typedef struct packed {
    logic [REG_ADR_W-1:0] adr;
    logic [DATA_W-1:0]    data;
  } entry_t;

  logic                 haz;
  logic                 no_credit;
  logic                 alu_issue;
  logic [CRW-1:0]       credits_q, credits_d;
  rr_e                  rr_q, rr_d;
  logic                 req_a, req_m;
  logic                 grant_a, grant_m;
  entry_t               fifo_wdata;
  entry_t               fifo_rdata;
  logic                 fifo_empty;
  logic                 fifo_full;
  logic [FCW-1:0]       fifo_count;
  logic                 unused_fifo;
  logic                 regwrite_q, regwrite_d;
  logic [REG_ADR_W-1:0] wb_adr_q, wb_adr_d;
  logic [DATA_W-1:0]    wb_data_q, wb_data_d;

  // WAW term keeps the scoreboard set and clear on different registers.
  assign haz = (id_rs_use & register_invalid[id_rs_adr])
             | (id_rt_use & register_invalid[id_rt_adr])
             | (id_rd_write & register_invalid[id_rd_adr]);

  assign no_credit       = (credits_q == '0);
  assign id_stall        = id_valid
                         & (haz | (id_rd_write & ~id_is_load & no_credit));
  assign regwrite_cur    = id_valid & ~id_stall & id_rd_write;
  assign regwrite_adr_id = id_rd_adr;
  assign alu_issue       = regwrite_cur & ~id_is_load;

  always_comb begin
    credits_d = credits_q;
    unique case ({alu_issue, grant_a})
      2'b10:   credits_d = credits_q - CRW'(1);
      2'b01:   credits_d = credits_q + CRW'(1);
      default: credits_d = credits_q;
    endcase
  end

  assign fifo_wdata = '{adr: alu_wb_adr, data: alu_wb_data};

  wb_fifo #(
    .DEPTH (ALU_BUF),
    .T     (entry_t)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (reset),
    .push_i  (alu_wb_valid),
    .wdata_i (fifo_wdata),
    .pop_i   (grant_a),
    .rdata_o (fifo_rdata),
    .count_o (fifo_count),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  assign unused_fifo = ^{fifo_count, fifo_full};

  assign req_a = ~fifo_empty;
  assign req_m = mem_wb_valid;

  // rr only advances when both sides compete.
  always_comb begin
    grant_a = 1'b0;
    grant_m = 1'b0;
    rr_d    = rr_q;
    unique case (1'b1)
      req_a & req_m: begin
        grant_a = (rr_q == RR_ALU);
        grant_m = (rr_q == RR_MEM);
        rr_d    = (rr_q == RR_ALU) ? RR_MEM : RR_ALU;
      end
      req_a & ~req_m: grant_a = 1'b1;
      ~req_a & req_m: grant_m = 1'b1;
      default: ;
    endcase
  end

  assign mem_wb_ready = grant_m;

  always_comb begin
    regwrite_d = grant_a | grant_m;
    wb_adr_d   = wb_adr_q;
    wb_data_d  = wb_data_q;
    if (grant_a) begin
      wb_adr_d  = fifo_rdata.adr;
      wb_data_d = fifo_rdata.data;
    end else if (grant_m) begin
      wb_adr_d  = mem_wb_adr;
      wb_data_d = mem_wb_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      credits_q  <= CRW'(ALU_BUF);
      rr_q       <= RR_ALU;
      regwrite_q <= 1'b0;
      wb_adr_q   <= '0;
      wb_data_q  <= '0;
    end else begin
      credits_q  <= credits_d;
      rr_q       <= rr_d;
      regwrite_q <= regwrite_d;
      wb_adr_q   <= wb_adr_d;
      wb_data_q  <= wb_data_d;
    end
  end

  assign regwrite      = regwrite_q;
  assign regwrite_adr  = wb_adr_q;
  assign regwrite_data = wb_data_q;

endmodule
